// File: rtl/vga_window_controller.sv
// Programmable VGA timing with a windowed host-pixel fetch and border fill; oRequest at t+1, colour/sync/blank at t+2.
// No backpressure: the host must present a pixel the cycle after every oRequest.
module vga_window_controller #(
  parameter int COLOR_W = 4,
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0
) (
  input  logic                   iVGA_CLK,
  input  logic                   iRST,
  input  logic [COLOR_W-1:0]     iRed,
  input  logic [COLOR_W-1:0]     iGreen,
  input  logic [COLOR_W-1:0]     iBlue,
  input  logic [15:0]            iWin_X,
  input  logic [15:0]            iWin_Y,
  input  logic [15:0]            iWin_W,
  input  logic [15:0]            iWin_H,
  input  logic [3*COLOR_W-1:0]   iBorder,
  output logic                   oRequest,
  output logic                   oFrameDone,
  output logic [COLOR_W-1:0]     oVGA_R,
  output logic [COLOR_W-1:0]     oVGA_G,
  output logic [COLOR_W-1:0]     oVGA_B,
  output logic                   oVGA_H_SYNC,
  output logic                   oVGA_V_SYNC,
  output logic                   oVGA_BLANK_n,
  output logic                   oVGA_CLOCK
);

  localparam int H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;
  localparam int CW3     = 3 * COLOR_W;
  localparam logic HS_LVL = HS_POL[0];
  localparam logic VS_LVL = VS_POL[0];

  logic [15:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0]    win_x_q, win_x_d, win_y_q, win_y_d;
  logic [15:0]    win_w_q, win_w_d, win_h_q, win_h_d;
  logic           load_pend_q, load_pend_d;
  logic           req_q, req_d, fd_q, fd_d;
  logic           win1_q, win1_d, act1_q, act1_d;
  logic           hs1_q, hs1_d, vs1_q, vs1_d;
  logic           hs2_q, hs2_d, vs2_q, vs2_d, blank_q, blank_d;
  logic [CW3-1:0] rgb_q, rgb_d;

  logic        h_wrap, frame_pt, active, in_win;
  logic [15:0] ex, ey, ew, eh;

  always_comb begin
    h_wrap  = (h_cnt_q == 16'(H_TOTAL - 1));
    h_cnt_d = h_wrap ? 16'd0 : h_cnt_q + 16'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == 16'(V_TOTAL - 1)) ? 16'd0 : v_cnt_q + 16'd1;
    end

    frame_pt = (h_cnt_q == 16'd0) && (v_cnt_q == 16'(V_ACT));

    // The first cycle after reset uses the live inputs so line 0 is already windowed.
    ex = load_pend_q ? iWin_X : win_x_q;
    ey = load_pend_q ? iWin_Y : win_y_q;
    ew = load_pend_q ? iWin_W : win_w_q;
    eh = load_pend_q ? iWin_H : win_h_q;

    win_x_d = win_x_q;
    win_y_d = win_y_q;
    win_w_d = win_w_q;
    win_h_d = win_h_q;
    if (load_pend_q || frame_pt) begin
      win_x_d = iWin_X;
      win_y_d = iWin_Y;
      win_w_d = iWin_W;
      win_h_d = iWin_H;
    end
    load_pend_d = 1'b0;

    active = (h_cnt_q < 16'(H_ACT)) && (v_cnt_q < 16'(V_ACT));
    in_win = active
          && ({1'b0, h_cnt_q} >= {1'b0, ex}) && ({1'b0, h_cnt_q} < ({1'b0, ex} + {1'b0, ew}))
          && ({1'b0, v_cnt_q} >= {1'b0, ey}) && ({1'b0, v_cnt_q} < ({1'b0, ey} + {1'b0, eh}));

    req_d  = in_win;
    fd_d   = frame_pt;
    win1_d = in_win;
    act1_d = active;
    hs1_d  = (h_cnt_q >= 16'(H_ACT + H_FRONT)) && (h_cnt_q < 16'(H_ACT + H_FRONT + H_SYNC));
    vs1_d  = (v_cnt_q >= 16'(V_ACT + V_FRONT)) && (v_cnt_q < 16'(V_ACT + V_FRONT + V_SYNC));

    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    blank_d = act1_q;
    if (win1_q) begin
      rgb_d = {iBlue, iGreen, iRed};
    end else if (act1_q) begin
      rgb_d = iBorder;
    end else begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_w_q     <= '0;
      win_h_q     <= '0;
      load_pend_q <= 1'b1;
      req_q       <= 1'b0;
      fd_q        <= 1'b0;
      win1_q      <= 1'b0;
      act1_q      <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      win_w_q     <= win_w_d;
      win_h_q     <= win_h_d;
      load_pend_q <= load_pend_d;
      req_q       <= req_d;
      fd_q        <= fd_d;
      win1_q      <= win1_d;
      act1_q      <= act1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
    end
  end

  // Sync flops hold "asserted"; polarity is applied on the way out.
  assign oVGA_H_SYNC  = hs2_q ? HS_LVL : ~HS_LVL;
  assign oVGA_V_SYNC  = vs2_q ? VS_LVL : ~VS_LVL;
  assign oVGA_BLANK_n = blank_q;
  assign oRequest     = req_q;
  assign oFrameDone   = fd_q;
  assign oVGA_R       = rgb_q[COLOR_W-1:0];
  assign oVGA_G       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign oVGA_B       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign oVGA_CLOCK   = iVGA_CLK;

endmodule

// File: tb/tb_vga_window_controller.sv
// Directed bench for vga_window_controller on a shrunken 24x15 raster (16x10 active, 360-cycle frame).
module tb_vga_window_controller;
  localparam int CW = 4;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 10, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] r, g, b;
  logic [15:0]   wx, wy, ww, wh;
  logic [11:0]   bord;
  logic          o_req, o_fd, o_hs, o_vs, o_blank, o_clk;
  logic [CW-1:0] o_r, o_g, o_b;

  vga_window_controller #(
    .COLOR_W(CW), .H_ACT(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .HS_POL(0), .VS_POL(0)
  ) dut (
    .iVGA_CLK(clk), .iRST(rst), .iRed(r), .iGreen(g), .iBlue(b),
    .iWin_X(wx), .iWin_Y(wy), .iWin_W(ww), .iWin_H(wh), .iBorder(bord),
    .oRequest(o_req), .oFrameDone(o_fd), .oVGA_R(o_r), .oVGA_G(o_g), .oVGA_B(o_b),
    .oVGA_H_SYNC(o_hs), .oVGA_V_SYNC(o_vs), .oVGA_BLANK_n(o_blank), .oVGA_CLOCK(o_clk)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference raster position and shadowed window
  int k, cur_h, cur_v, mx, my, mw, mh;
  int e_req, e_fd, e_col, e_hs, e_vs, e_blk;
  int cur_req, fd_k, first_hs;
  logic p_act, p_win, p_hs, p_vs;
  logic [11:0] p_dat, p_bord, pix;

  task automatic tick();
    logic act, win, hs, vs, fd;
    logic [11:0] ecol;
    @(posedge clk); #1;
    cur_h = k % HT;
    cur_v = (k / HT) % VT;
    if (k == 0 || (cur_h == 0 && cur_v == VA)) begin
      mx = int'(wx); my = int'(wy); mw = int'(ww); mh = int'(wh);
    end
    act = (cur_h < HA) && (cur_v < VA);
    win = act && cur_h >= mx && cur_h < mx + mw && cur_v >= my && cur_v < my + mh;
    hs  = (cur_h >= HA + HF) && (cur_h < HA + HF + HS);
    vs  = (cur_v >= VA + VF) && (cur_v < VA + VF + VS);
    fd  = (cur_h == 0) && (cur_v == VA);
    if (o_req !== win) e_req++;
    if (o_fd !== fd) e_fd++;
    if (o_req === 1'b1) cur_req++;
    if (k >= 1) begin
      ecol = p_win ? p_dat : (p_act ? p_bord : 12'h000);
      if ({o_b, o_g, o_r} !== ecol) e_col++;
      if (o_hs !== ~p_hs) e_hs++;
      if (o_vs !== ~p_vs) e_vs++;
      if (o_blank !== p_act) e_blk++;
      if (first_hs < 0 && o_hs === 1'b0) first_hs = k + 1;
    end
    pix = pix + 12'd37;
    {b, g, r} = pix;
    p_act = act; p_win = win; p_hs = hs; p_vs = vs;
    p_dat = pix; p_bord = bord;
    k++;
  endtask

  task automatic run_to_fd(input string tag, input int exp_req, input int exp_gap);
    logic seen;
    int got;
    seen = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !seen; i++) begin
      tick();
      if (o_fd === 1'b1) seen = 1'b1;
    end
    chk({tag, "_fd_seen"}, 32'(seen), 32'd1);
    got = cur_req;
    cur_req = 0;
    chk({tag, "_req"}, got, exp_req);
    chk({tag, "_fd_gap"}, (k - 1) - fd_k, exp_gap);
    fd_k = k - 1;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    k = 0; first_hs = -1; cur_req = 0; fd_k = 0;
  endtask

  initial begin
    rst = 1'b1;
    {b, g, r} = 12'h000;
    pix = 12'h000;
    wx = 16'd2; wy = 16'd1; ww = 16'd8; wh = 16'd6;
    bord = 12'hA5C;
    e_req = 0; e_fd = 0; e_col = 0; e_hs = 0; e_vs = 0; e_blk = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("por_outs", {15'd0, o_req, o_fd, o_blank, o_hs, o_vs, o_r, o_g, o_b}, {15'd0, 5'b00011, 12'h000});
    end
    release_rst();

    // 8x6 window fully on screen: 48 requests per frame
    run_to_fd("frame0", 48, 240);
    run_to_fd("frame1", 48, 360);

    // Window rewritten on line 5: current frame keeps the old one
    for (int i = 0; i < HT * VT && !(cur_v == 5 && cur_h == 0); i++) tick();
    wx = 16'd12; ww = 16'd10; wy = 16'd7; wh = 16'd5;
    run_to_fd("midwin_old", 48, 360);
    run_to_fd("clip", 12, 360);

    // Zero width: border only
    ww = 16'd0;
    bord = 12'h3C7;
    run_to_fd("w0_old", 12, 360);
    run_to_fd("w0_none", 0, 360);

    // Mid-line reset pulse
    wx = 16'd2; wy = 16'd1; ww = 16'd8; wh = 16'd6;
    bord = 12'hA5C;
    for (int i = 0; i < HT * VT && !(cur_v == 3 && cur_h == 5); i++) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_outs", {15'd0, o_req, o_fd, o_blank, o_hs, o_vs, o_r, o_g, o_b}, {15'd0, 5'b00011, 12'h000});
    end
    release_rst();
    for (int i = 0; i < 2 * HT && first_hs < 0; i++) tick();
    chk("hs_after_rst", first_hs, HA + HF + 2);
    run_to_fd("post_rst", 48, 240);

    chk("req_pattern", e_req, 0);
    chk("framedone_pattern", e_fd, 0);
    chk("colour_pattern", e_col, 0);
    chk("hsync_pattern", e_hs, 0);
    chk("vsync_pattern", e_vs, 0);
    chk("blank_pattern", e_blk, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
